// File: rtl/conv2_maxpool_relu_if.sv
// Bus between the conv2 sum stream, the ReLU/2x2 max-pool block and the fully connected stage.
interface conv2_maxpool_relu_if #(
  parameter int unsigned CONV_BIT = 14,
  parameter int unsigned OUT_BIT  = 12
);
  logic                       valid_in;
  logic signed [CONV_BIT-1:0] conv_in_1;
  logic signed [CONV_BIT-1:0] conv_in_2;
  logic signed [CONV_BIT-1:0] conv_in_3;
  logic [OUT_BIT-1:0]         pool_out_1;
  logic [OUT_BIT-1:0]         pool_out_2;
  logic [OUT_BIT-1:0]         pool_out_3;
  logic                       valid_out;
  logic                       frame_done;

  modport master (
    output valid_in, conv_in_1, conv_in_2, conv_in_3,
    input  pool_out_1, pool_out_2, pool_out_3, valid_out, frame_done
  );

  modport slave (
    input  valid_in, conv_in_1, conv_in_2, conv_in_3,
    output pool_out_1, pool_out_2, pool_out_3, valid_out, frame_done
  );
endinterface

// File: rtl/conv2_maxpool_relu.sv
// ReLU + non-overlapping 2x2 max-pool over three conv2 channels, 12-bit unsigned output.
// Optional macro CONV2_POOL_SAT_EN: saturate to 12 bits instead of halving.
module conv2_maxpool_relu #(
  parameter int unsigned CONV_BIT  = 14,
  parameter int unsigned OUT_BIT   = 12,
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned IN_HEIGHT = 8
) (
  input logic                clk,
  input logic                rst,
  conv2_maxpool_relu_if.slave bus
);

  localparam int unsigned NCH    = 3;
  localparam int unsigned R_W    = CONV_BIT - 1;
  localparam int unsigned HALF_W = IN_WIDTH / 2;
  localparam int unsigned COL_W  = (IN_WIDTH > 2) ? $clog2(IN_WIDTH) : 2;
  localparam int unsigned ROW_W  = $clog2(IN_HEIGHT);
  localparam int unsigned IDX_W  = COL_W - 1;

  typedef enum logic {EVEN_ROW, ODD_ROW} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [COL_W-1:0]     col;
  logic [ROW_W-1:0]     row;
  logic                 col_last;
  logic                 row_last;
  logic [IDX_W-1:0]     idx;

  logic signed [CONV_BIT-1:0] conv   [NCH];
  logic [R_W-1:0]             relu   [NCH];
  logic [R_W-1:0]             hold   [NCH];
  logic [R_W-1:0]             line   [NCH][HALF_W];
  logic [OUT_BIT-1:0]         pool_q [NCH];
  logic                       valid_q;
  logic                       done_q;

  function automatic logic [R_W-1:0] vmax(input logic [R_W-1:0] a, input logic [R_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [OUT_BIT-1:0] fmt(input logic [R_W-1:0] v);
`ifdef CONV2_POOL_SAT_EN
    return (v > R_W'((1 << OUT_BIT) - 1)) ? '1 : OUT_BIT'(v);
`else
    return OUT_BIT'(v >> 1);
`endif
  endfunction

  assign conv[0] = bus.conv_in_1;
  assign conv[1] = bus.conv_in_2;
  assign conv[2] = bus.conv_in_3;

  assign col_last = (col == COL_W'(IN_WIDTH - 1));
  assign row_last = (row == ROW_W'(IN_HEIGHT - 1));
  assign idx      = col[COL_W-1:1];

  // Negative sums clamp to zero; the sign bit is dropped from the kept magnitude.
  always_comb begin
    for (int ch = 0; ch < NCH; ch++) begin
      relu[ch] = conv[ch][CONV_BIT-1] ? '0 : conv[ch][R_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EVEN_ROW;
    else     state <= state_nxt;
  end

  // Row parity follows every column wrap.
  always_comb begin
    state_nxt = state;
    if (bus.valid_in && col_last) begin
      state_nxt = (state == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (bus.valid_in) begin
      col <= col_last ? '0 : col + COL_W'(1);
      if (col_last) row <= row_last ? '0 : row + ROW_W'(1);
    end
  end

  // Even rows fold pairs into the line buffer; odd rows merge with it and emit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int ch = 0; ch < NCH; ch++) begin
        hold[ch]   <= '0;
        pool_q[ch] <= '0;
        for (int k = 0; k < HALF_W; k++) line[ch][k] <= '0;
      end
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      if (bus.valid_in) begin
        for (int ch = 0; ch < NCH; ch++) begin
          if (state == EVEN_ROW) begin
            if (!col[0]) hold[ch]      <= relu[ch];
            else         line[ch][idx] <= vmax(hold[ch], relu[ch]);
          end else begin
            if (!col[0]) hold[ch]   <= vmax(line[ch][idx], relu[ch]);
            else         pool_q[ch] <= fmt(vmax(hold[ch], relu[ch]));
          end
        end
        if (state == ODD_ROW && col[0]) begin
          valid_q <= 1'b1;
          done_q  <= row_last && col_last;
        end
      end
    end
  end

  assign bus.pool_out_1 = pool_q[0];
  assign bus.pool_out_2 = pool_q[1];
  assign bus.pool_out_3 = pool_q[2];
  assign bus.valid_out  = valid_q;
  assign bus.frame_done = done_q;

endmodule

// File: doc/conv2_maxpool_relu.md
# conv2_maxpool_relu

Second-stage activation and pooling block for the MNIST CNN. It consumes the three-channel 14-bit signed sum stream from the conv2 calculation stage (8×8 pixels per channel per frame, row-major). It applies ReLU, reduces each non-overlapping 2×2 window to its maximum, and emits a 4×4×3 feature map in 12-bit unsigned form to the fully connected stage.

## Interface

Parameters:
- `CONV_BIT`, 14: input sample width, signed.
- `OUT_BIT`, 12: output sample width, unsigned.
- `IN_WIDTH`, 8: conv2 output columns; must be even.
- `IN_HEIGHT`, 8: conv2 output rows; must be even.

Ports (one clock; reset is asynchronous and active-high):
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.
- `valid_in` input 1: the current cycle carries one pixel for all three channels.
- `conv_in_1`, `conv_in_2`, `conv_in_3` input `CONV_BIT`, signed: channel sums.
- `pool_out_1`, `pool_out_2`, `pool_out_3` output `OUT_BIT`, registered: pooled values.
- `valid_out` output 1, registered: single-cycle qualifier for `pool_out_*`.
- `frame_done` output 1, registered: pulses together with the last (16th) output of a frame.

## Operation

- Input handling:
  - Inputs are sampled only when `valid_in`=1. Bubbles of any length are allowed between pixels.
  - There is no backpressure; the downstream stage must accept one output per cycle.
- ReLU per channel:
  - `r = conv_in[13] ? 0 : conv_in[12:0]`, a 13-bit unsigned value.
  - All later comparisons are unsigned 13-bit. When values are equal, either may be kept.
- Counters, advanced on each accepted pixel:
  - `col` runs 0..IN_WIDTH-1.
  - `row` runs 0..IN_HEIGHT-1 and increments when `col` wraps.
  - After pixel (IN_HEIGHT-1, IN_WIDTH-1) both wrap to 0, and the next pixel starts a new frame with no idle cycle needed.
- State machine:
  - States are `EVEN_ROW` and `ODD_ROW`; reset state is `EVEN_ROW`.
  - The state toggles on every `col` wrap.
- Storage per channel:
  - `hold`: one 13-bit register.
  - `line`: IN_WIDTH/2 entries of 13 bits, indexed by `col>>1`.
- Behaviour per accepted pixel:
  - `EVEN_ROW`, even col: `hold <= r`.
  - `EVEN_ROW`, odd col: `line[col>>1] <= max(hold, r)`.
  - `ODD_ROW`, even col: `hold <= max(line[col>>1], r)`.
  - `ODD_ROW`, odd col: the window is complete. Register `pool_out = fmt(max(hold, r))` and assert `valid_out`.
- `fmt` is the 13→12 bit conversion; see Configuration.
- `frame_done` is asserted in the same cycle as `valid_out` when the completing pixel is (IN_HEIGHT-1, IN_WIDTH-1).
- All three channels share the counters and the state. Each channel keeps its own `hold` and `line`.

## Timing

- Reset values:
  - `pool_out_*`=0, `valid_out`=0, `frame_done`=0.
  - `col`=0, `row`=0, state=`EVEN_ROW`, all `hold`/`line` entries 0.
- Reset asserted mid-frame discards the partial frame. The first `valid_in` after release is pixel (0,0).
- Latency: `valid_out` rises on the clock edge that samples the completing pixel, so it is visible the cycle after that pixel. It stays high for exactly 1 cycle.
- Output rate:
  - At most one output every 2 accepted pixels.
  - IN_HEIGHT/2 × IN_WIDTH/2 = 16 outputs per frame.
- `pool_out_*` hold their value between `valid_out` pulses.
- `valid_in` low: no counter, state, or storage change, and `valid_out` goes to 0 on the next edge.
- Back-to-back frames: the (0,0) pixel of frame N+1 may arrive the cycle after (7,7) of frame N. The `line` contents are overwritten before they are read, so no clear is needed.

## Configuration

- `CONV2_POOL_SAT_EN` defined:
  - `fmt(v) = (v > 4095) ? 12'hFFF : v[11:0]`, i.e. unsigned saturation.
- `CONV2_POOL_SAT_EN` undefined:
  - `fmt(v) = v[12:1]`, i.e. scale by ½ with truncation and no saturation logic.

## Test plan

- Ramp: channel 1 pixel = row*8+col, one frame with no bubbles.
  - Required: 16 outputs (2i+1)*8+(2j+1), i.e. 9, 11, 13, 15, 25, … 63.
  - With the macro the values are unchanged; without it they are halved (4, 5, 6, 7, 12, … 31).
  - `frame_done` occurs only with the output 63.
- Negative inputs: channel 2 = −(row*8+col)−1 and channel 3 = −8192 for all pixels.
  - Required: every `pool_out_2` and `pool_out_3` is 0, while channel 1 is unaffected.
- Single peak: all pixels 0 except (5,2)=5000 on channel 1.
  - Required: the output for window (2,1), the 10th output, is 4095 with the macro and 2500 without it. All other outputs are 0.
- Bubbles: replay the ramp with random `valid_in` gaps of 0–5 cycles.
  - Required: the same 16-value sequence, each `valid_out` pulse exactly 1 cycle, and no output during gaps.
- Reset mid-frame: assert `rst` after pixel (3,4), then send a full ramp frame.
  - Required: outputs 0 and `valid_out`=0 during reset, then the exact ramp sequence and a single `frame_done`.
- Back-to-back: two ramp frames with continuous `valid_in`.
  - Required: 32 outputs, and `frame_done` on the 16th and 32nd.
